i2s_tdm_tx: RTL



---
 rtl/i2s_pkg.sv | 31 +++
 rtl/i2s_sample_fifo.sv | 70 +++++++
 rtl/i2s_tdm_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S/TDM transmit path.
// Mode and state encodings plus the mode resolution helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    I2S_PHILIPS = 2'd0,
    I2S_LJ      = 2'd1,
    I2S_TDM     = 2'd2
  } i2s_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_e;

  // Two-slot framings only make sense for stereo; anything else is TDM.
  function automatic i2s_mode_e mode_decode(
    input logic [1:0] m,
    input int         ch
  );
    i2s_mode_e r;
    r = I2S_TDM;
    if (ch == 2) begin
      if (m == 2'd0) r = I2S_PHILIPS;
      else if (m == 2'd1) r = I2S_LJ;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Interleaved sample FIFO: single push, pop of N samples at once.
// The N oldest samples are always visible on o_data.
module i2s_sample_fifo #(
  parameter int W  = 24,
  parameter int AW = 3,
  parameter int N  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [W-1:0]       i_data,
  output logic               o_ready,
  input  logic               i_pop,
  output logic [N-1:0][W-1:0] o_data,
  output logic [AW:0]        o_level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] NP   = AW'(N);
  localparam logic [AW:0]   NL   = (AW+1)'(N);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok;

  assign o_ready = level_q != FULL;
  assign push_ok = i_push & o_ready;
  assign o_level = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      level_d  = level_d + 1'b1;
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + NP;
      level_d  = level_d - NL;
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      o_data[i] = mem_q[rd_ptr_q + AW'(i)];
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM transmitter with divided SCK.
// Frames are loaded atomically from the FIFO and never truncated.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int FIFO_AW  = 3,
  parameter int DIV_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic [DIV_W-1:0]    i_clk_div,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [SAMPLE_W-1:0] i_s_data,
  input  logic                i_clr_underrun,
  output logic [FIFO_AW:0]    o_fifo_level,
  output logic                o_underrun,
  output logic                o_busy,
  output logic                o_sck,
  output logic                o_ws,
  output logic                o_sd
);

  localparam int FRAME_W = CHANNELS * SLOT_W;
  localparam int SLOT_CW = $clog2(SLOT_W);
  localparam int CH_CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(SLOT_W - 1);
  localparam logic [CH_CW-1:0]   CH_LAST   = CH_CW'(CHANNELS - 1);
  localparam logic [FIFO_AW:0]   CH_LVL    = (FIFO_AW+1)'(CHANNELS);

  i2s_state_e state_q, state_d;
  i2s_mode_e  mode_q, mode_d, start_mode;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               sck_q, sck_d;
  logic               ws_q, ws_d;
  logic               und_q, und_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [SLOT_CW-1:0] bis_q, bis_d;
  logic [CH_CW-1:0]   slot_q, slot_d;

  logic                             busy;
  logic                             start;
  logic                             tick;
  logic                             adv;
  logic                             frame_end;
  logic                             have_frame;
  logic                             load;
  logic                             pop;
  logic [CHANNELS-1:0][SAMPLE_W-1:0] fifo_data;
  logic [FRAME_W-1:0]               frame_word;

  i2s_sample_fifo #(
    .W  (SAMPLE_W),
    .AW (FIFO_AW),
    .N  (CHANNELS)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_s_valid),
    .i_data  (i_s_data),
    .o_ready (o_s_ready),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_level (o_fifo_level)
  );

  assign busy       = state_q != ST_IDLE;
  assign start      = (state_q == ST_IDLE) & i_enable;
  assign start_mode = mode_decode(i_mode, CHANNELS);
  assign tick       = busy & (cnt_q == div_q);
  assign adv        = tick & sck_q;
  assign frame_end  = adv & (bis_q == SLOT_LAST)
                    & (slot_q == CH_LAST);
  assign have_frame = o_fifo_level >= CH_LVL;
  assign load       = (start & (start_mode == I2S_LJ))
                    | (frame_end & i_enable);
  assign pop        = load & have_frame;

  // ch0 sits at the top so the frame shifts out MSB-first.
  always_comb begin
    frame_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      frame_word[FRAME_W-1-c*SLOT_W -: SAMPLE_W] = fifo_data[c];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_enable)
          state_d = frame_end ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_enable)       state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = busy;
    o_sck      = sck_q;
    o_ws       = ws_q;
    o_sd       = busy & sr_q[FRAME_W-1];
    o_underrun = und_q;
  end

  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    sck_d  = sck_q;
    ws_d   = ws_q;
    sr_d   = sr_q;
    bis_d  = bis_q;
    slot_d = slot_q;
    und_d  = und_q;
    if (i_clr_underrun) und_d = 1'b0;
    if (start) begin
      mode_d = start_mode;
      div_d  = i_clk_div;
      cnt_d  = '0;
      sck_d  = 1'b0;
      sr_d   = '0;
      // Non-LJ modes open with a lead-in bit posing as the last bit.
      if (start_mode == I2S_LJ) begin
        bis_d  = '0;
        slot_d = '0;
      end else begin
        bis_d  = SLOT_LAST;
        slot_d = CH_LAST;
      end
    end else if (tick) begin
      cnt_d = '0;
      sck_d = ~sck_q;
      if (frame_end) begin
        bis_d  = '0;
        slot_d = '0;
        div_d  = i_clk_div;
        if (!i_enable) sr_d = '0;
      end else if (adv) begin
        sr_d = sr_q << 1;
        if (bis_q == SLOT_LAST) begin
          bis_d  = '0;
          slot_d = slot_q + 1'b1;
        end else begin
          bis_d = bis_q + 1'b1;
        end
      end
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (load) begin
      sr_d = have_frame ? frame_word : '0;
      if (!have_frame) und_d = 1'b1;
    end
    if (start | adv) begin
      if (frame_end & !i_enable) begin
        ws_d = 1'b0;
      end else begin
        unique case (1'b1)
          mode_d == I2S_LJ:
            ws_d = slot_d == '0;
          mode_d == I2S_PHILIPS:
            ws_d = (bis_d == SLOT_LAST) ? ~slot_d[0]
                                        : slot_d[0];
          default:
            ws_d = i_enable & (slot_d == CH_LAST)
                 & (bis_d == SLOT_LAST);
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= I2S_PHILIPS;
      div_q  <= '0;
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      ws_q   <= 1'b0;
      sr_q   <= '0;
      bis_q  <= '0;
      slot_q <= '0;
      und_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      ws_q   <= ws_d;
      sr_q   <= sr_d;
      bis_q  <= bis_d;
      slot_q <= slot_d;
      und_q  <= und_d;
    end
  end

endmodule
